serializer: RTL and testbench

SERIALIZER -- requirements
Module: serializer

---
 rtl/serializer_if.sv | 28 ++
 rtl/serializer.sv | 126 ++++++++++++
 tb/tb_serializer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serializer_if.sv
// Parallel-word input and serial-bit output bundle of the serializer.
// master: word source / bit sink; slave: the serializer itself.
interface serializer_if;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_val_i;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    modport master (
        output data_i,
        output data_mod_i,
        output data_val_i,
        input  ser_data_o,
        input  ser_data_val_o,
        input  busy_o
    );

    modport slave (
        input  data_i,
        input  data_mod_i,
        input  data_val_i,
        output ser_data_o,
        output ser_data_val_o,
        output busy_o
    );
endinterface

// File: rtl/serializer.sv
// MSB-first word serializer with a 1..16 bit length field.
// Optional trailing even-parity bit is enabled by defining SERIALIZER_PARITY_EN.
module serializer (
    input  logic               clk_i,
    input  logic               srst_n_i,
    serializer_if.slave        bus,
    output logic [1:0]         state_o
);

    // Handshake: a word is taken on a rising edge where data_val_i=1 and
    // busy_o=0 and data_mod_i is not 1 or 2; there is no back-pressure other
    // than busy_o, so a valid word presented while busy_o=1 is simply dropped.

`ifdef SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1
    } state_t;
`endif

    state_t      state_q;
    logic [15:0] shift_q;
    logic [4:0]  cnt_q;
    logic        ser_q;
    logic        ser_val_q;
    logic        busy_q;
`ifdef SERIALIZER_PARITY_EN
    logic        par_q;
`endif

    logic        mod_ok;
    logic        accept;
    logic [4:0]  n_bits;
    logic        last_bit;
    logic [4:0]  cnt_dec;

    assign mod_ok   = (bus.data_mod_i != 4'd1) && (bus.data_mod_i != 4'd2);
    assign accept   = bus.data_val_i && mod_ok && (state_q == ST_IDLE);
    assign n_bits   = (bus.data_mod_i == 4'd0) ? 5'd16 : {1'b0, bus.data_mod_i};
    // cnt_q holds the number of bits still owed, including the one on the wire
    assign last_bit = (cnt_q <= 5'd1);
    assign cnt_dec  = (cnt_q != 5'd0) ? (cnt_q - 5'd1) : 5'd0;

    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q   <= ST_IDLE;
            shift_q   <= 16'd0;
            cnt_q     <= 5'd0;
            ser_q     <= 1'b0;
            ser_val_q <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q   <= ST_SEND;
                        shift_q   <= {bus.data_i[14:0], 1'b0};
                        cnt_q     <= n_bits;
                        ser_q     <= bus.data_i[15];
                        ser_val_q <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
                        par_q     <= bus.data_i[15];
`endif
                    end
                end

                ST_SEND: begin
                    cnt_q <= cnt_dec;
                    if (last_bit) begin
                        shift_q <= 16'd0;
`ifdef SERIALIZER_PARITY_EN
                        state_q <= ST_PARITY;
                        ser_q   <= par_q;
`else
                        state_q   <= ST_IDLE;
                        ser_q     <= 1'b0;
                        ser_val_q <= 1'b0;
                        busy_q    <= 1'b0;
`endif
                    end else begin
                        ser_q   <= shift_q[15];
                        shift_q <= {shift_q[14:0], 1'b0};
`ifdef SERIALIZER_PARITY_EN
                        par_q   <= par_q ^ shift_q[15];
`endif
                    end
                end

`ifdef SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    state_q   <= ST_IDLE;
                    ser_q     <= 1'b0;
                    ser_val_q <= 1'b0;
                    busy_q    <= 1'b0;
                    par_q     <= 1'b0;
                end
`endif

                default: begin
                    state_q   <= ST_IDLE;
                    shift_q   <= 16'd0;
                    cnt_q     <= 5'd0;
                    ser_q     <= 1'b0;
                    ser_val_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ser_data_o     = ser_q;
    assign bus.ser_data_val_o = ser_val_q;
    assign bus.busy_o         = busy_q;
    assign state_o            = state_q;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: a bit-list reference model predicts
// every output cycle; directed scenarios add whole-word checks.
module tb_serializer;

    logic       clk;
    logic       srst_n;
    logic [1:0] state_dbg;

    serializer_if sif ();

    serializer dut (
        .clk_i    (clk),
        .srst_n_i (srst_n),
        .bus      (sif),
        .state_o  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: each accepted word becomes a list of output bits
    logic [0:0] exp_q[$];
    logic       m_val;
    logic       m_bit;
    int         n_acc;
    int         n_chk;
    int         n_fail;

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    task automatic model_edge();
        int   n;
        logic p;
        if (!srst_n) begin
            m_val = 1'b0;
            m_bit = 1'b0;
            exp_q.delete();
        end else if (m_val) begin
            if (exp_q.size() > 0) begin
                m_bit = exp_q.pop_front();
            end else begin
                m_val = 1'b0;
                m_bit = 1'b0;
            end
        end else if (sif.data_val_i && sif.data_mod_i != 4'd1 && sif.data_mod_i != 4'd2) begin
            n = (sif.data_mod_i == 4'd0) ? 16 : int'(sif.data_mod_i);
            p = 1'b0;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back(sif.data_i[15-i]);
                p = p ^ sif.data_i[15-i];
            end
            if (PAR == 1) exp_q.push_back(p);
            m_bit = exp_q.pop_front();
            m_val = 1'b1;
            n_acc++;
        end
    endtask

    // inputs change 1 time unit after the edge; outputs are sampled there too
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic val, input logic [15:0] d, input logic [3:0] m);
        sif.data_val_i = val;
        sif.data_i     = d;
        sif.data_mod_i = m;
    endtask

    task automatic test_reset();
        srst_n = 1'b0;
        drive(1'b1, 16'hFFFF, 4'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_outputs c%0d: val/data/busy=%b%b%b required 000",
                         c, sif.ser_data_val_o, sif.ser_data_o, sif.busy_o);
            end
        end
        // first edge with reset released must accept
        srst_n = 1'b1;
        drive(1'b1, 16'hA5C3, 4'd0);
        tick();
        n_chk++;
        if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_first_accept: val/data/busy=%b%b%b required 111",
                     sif.ser_data_val_o, sif.ser_data_o, sif.busy_o);
        end
        drive(1'b0, 16'h0000, 4'd0);
        for (int c = 0; c < 20; c++) begin
            tick();
            n_chk++;
            if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== {m_val, m_bit, m_val}) begin
                n_fail++;
                $display("FAIL reset_drain c%0d: val/data/busy=%b%b%b required %b%b%b", c,
                         sif.ser_data_val_o, sif.ser_data_o, sif.busy_o, m_val, m_bit, m_val);
            end
        end
    endtask

    task automatic test_word(input logic [15:0] d, input logic [3:0] m,
                             input int exp_cnt, input logic [31:0] exp_col, input string name);
        logic [31:0] col;
        int          cnt;
        col = 32'd0;
        cnt = 0;
        drive(1'b1, d, m);
        for (int c = 0; c < 24; c++) begin
            tick();
            if (c == 0) drive(1'b0, 16'h0000, 4'd0);
            n_chk++;
            if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== {m_val, m_bit, m_val}) begin
                n_fail++;
                $display("FAIL %s c%0d: val/data/busy=%b%b%b required %b%b%b", name, c,
                         sif.ser_data_val_o, sif.ser_data_o, sif.busy_o, m_val, m_bit, m_val);
            end
            if (sif.ser_data_val_o === 1'b1) begin
                col = {col[30:0], sif.ser_data_o};
                cnt++;
            end
        end
        n_chk++;
        if (cnt != exp_cnt || col !== exp_col) begin
            n_fail++;
            $display("FAIL %s_word: %0d bits %h required %0d bits %h", name, cnt, col, exp_cnt, exp_col);
        end
    endtask

    task automatic test_invalid_mod();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 16'($urandom), (c < 3) ? 4'd1 : 4'd2);
            tick();
            n_chk++;
            if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL invalid_mod c%0d: val/data/busy=%b%b%b required 000",
                         c, sif.ser_data_val_o, sif.ser_data_o, sif.busy_o);
            end
        end
        drive(1'b0, 16'h0000, 4'd0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] col;
        logic [63:0] exp_col;
        int          cnt;
        int          acc0;
        col  = 64'd0;
        cnt  = 0;
        acc0 = n_acc;
        exp_col = (PAR == 1) ? {30'd0, 16'h8001, 1'b0, 16'h7FFE, 1'b0} : {32'd0, 16'h8001, 16'h7FFE};
        drive(1'b1, 16'h8001, 4'd0);
        for (int c = 0; c < 45; c++) begin
            tick();
            if (n_acc - acc0 >= 2) drive(1'b0, 16'h0000, 4'd0);
            else drive(1'b1, 16'h7FFE, 4'd0);
            n_chk++;
            if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== {m_val, m_bit, m_val}) begin
                n_fail++;
                $display("FAIL back_to_back c%0d: val/data/busy=%b%b%b required %b%b%b", c,
                         sif.ser_data_val_o, sif.ser_data_o, sif.busy_o, m_val, m_bit, m_val);
            end
            if (sif.ser_data_val_o === 1'b1) begin
                col = {col[62:0], sif.ser_data_o};
                cnt++;
            end
        end
        n_chk++;
        if (cnt != 32 + 2 * PAR || col !== exp_col) begin
            n_fail++;
            $display("FAIL back_to_back_words: %0d bits %h required %0d bits %h",
                     cnt, col, 32 + 2 * PAR, exp_col);
        end
    endtask

    task automatic test_input_change();
        logic [31:0] col;
        int          cnt;
        col = 32'd0;
        cnt = 0;
        drive(1'b1, 16'h1234, 4'd0);
        for (int c = 0; c < 24; c++) begin
            tick();
            if (c < 16 + PAR) drive(1'($urandom), 16'($urandom), 4'($urandom));
            else drive(1'b0, 16'($urandom), 4'($urandom));
            n_chk++;
            if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== {m_val, m_bit, m_val}) begin
                n_fail++;
                $display("FAIL input_change c%0d: val/data/busy=%b%b%b required %b%b%b", c,
                         sif.ser_data_val_o, sif.ser_data_o, sif.busy_o, m_val, m_bit, m_val);
            end
            if (sif.ser_data_val_o === 1'b1) begin
                col = {col[30:0], sif.ser_data_o};
                cnt++;
            end
        end
        n_chk++;
        if (cnt != 16 + PAR || col[15+PAR:PAR] !== 16'h1234) begin
            n_fail++;
            $display("FAIL input_change_word: %0d bits %h required %0d bits of 1234", cnt, col, 16 + PAR);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 16'hFFFF, 4'd0);
        tick();
        drive(1'b0, 16'h0000, 4'd0);
        for (int c = 0; c < 4; c++) tick();
        // fifth bit is on the wire now
        srst_n = 1'b0;
        tick();
        srst_n = 1'b1;
        n_chk++;
        if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: val/data/busy=%b%b%b required 000",
                     sif.ser_data_val_o, sif.ser_data_o, sif.busy_o);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_reset_no_resume c%0d: val/data/busy=%b%b%b required 000",
                         c, sif.ser_data_val_o, sif.ser_data_o, sif.busy_o);
            end
        end
        test_word(16'h0F0F, 4'd0, 16 + PAR, (PAR == 1) ? {15'd0, 16'h0F0F, 1'b0} : {16'd0, 16'h0F0F},
                  "after_reset");
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            srst_n = ($urandom_range(0, 80) != 0);
            drive($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom_range(0, 15)));
            tick();
            n_chk++;
            if ({sif.ser_data_val_o, sif.ser_data_o, sif.busy_o} !== {m_val, m_bit, m_val}) begin
                n_fail++;
                $display("FAIL random c%0d: val/data/busy=%b%b%b required %b%b%b", c,
                         sif.ser_data_val_o, sif.ser_data_o, sif.busy_o, m_val, m_bit, m_val);
            end
        end
        srst_n = 1'b1;
        drive(1'b0, 16'h0000, 4'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        n_acc  = 0;
        m_val  = 1'b0;
        m_bit  = 1'b0;
        srst_n = 1'b0;
        drive(1'b0, 16'h0000, 4'd0);

        test_reset();
        test_word(16'hA5C3, 4'd0, 16 + PAR, (PAR == 1) ? {15'd0, 16'hA5C3, 1'b0} : {16'd0, 16'hA5C3},
                  "a5c3");
        test_word(16'hF000, 4'd3, 3 + PAR, (PAR == 1) ? 32'hF : 32'h7, "f000_mod3");
        test_word(16'hE000, 4'd3, 3 + PAR, (PAR == 1) ? 32'hF : 32'h7, "e000_mod3");
        test_invalid_mod();
        test_back_to_back();
        test_input_change();
        test_mid_reset();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
